// File: rtl/norm_shift.sv
// norm_shift: multi-cycle left normalizer returning the shifted word and the shift amount
// NORM_FAST_EN enables 4-bit steps through long runs of leading zeros or sign bits
module norm_shift #(
   parameter int WIDTH = 32,
   parameter int SAW   = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] d,
   input  logic             arith,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] q,
   output logic [SAW-1:0]   sa,
   output logic             zero
);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t state, nstate;
   logic [WIDTH-1:0] r, nr;
   logic [SAW-1:0] cnt, ncnt;
   logic mode, zr, norm, fin, fast;
   always_comb begin
      norm = mode ? r[WIDTH-1] ^ r[WIDTH-2] : r[WIDTH-1];
      fin = norm || cnt == SAW'(WIDTH-1);
`ifdef NORM_FAST_EN
      fast = !norm && cnt <= SAW'(WIDTH-5) &&
             (mode ? (r[WIDTH-1:WIDTH-5] == '0 || r[WIDTH-1:WIDTH-5] == '1) : r[WIDTH-1:WIDTH-4] == '0);
`else
      fast = 1'b0;
`endif
      nstate = state;
      nr = r;
      ncnt = cnt;
      case (state)
         IDLE: if (start) begin
            nstate = SHIFT;
            nr = d;
            ncnt = '0;
         end
         SHIFT: if (fin) nstate = DONE;
         else begin
            nr = fast ? r << 4 : r << 1;
            ncnt = cnt + (fast ? SAW'(4) : SAW'(1));
         end
         default: nstate = IDLE;
      endcase
   end
   // the zero flag is captured with d but only published alongside q and sa
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         r <= '0;
         cnt <= '0;
         mode <= 1'b0;
         zr <= 1'b0;
         busy <= 1'b0;
         done <= 1'b0;
         q <= '0;
         sa <= '0;
         zero <= 1'b0;
      end else begin
         state <= nstate;
         r <= nr;
         cnt <= ncnt;
         busy <= nstate != IDLE;
         done <= nstate == DONE;
         if (state == IDLE && start) begin
            mode <= arith;
            zr <= d == '0;
         end
         if (state == SHIFT && fin) begin
            q <= r;
            sa <= cnt;
            zero <= zr;
         end
      end
   end
endmodule
